spi_master_mc: RTL
==================

// Module: spi_master_mc
// PURPOSE
//  Parametrised multi-chip-select SPI master, successor to the single SD-card SPI port on the SoC.
//  Byte/word transfers, all four CPOL/CPHA modes, runtime clock divider, CS hold across bursts.
//  Sits between the SoC peripheral register block and the board SPI pins (SD card, flash, ADC).
// PARAMETERS
//  DATA_W     8    bits per transfer, MSB first
//  NUM_CS     2    number of active-low chip selects
//  DIV_W      8    width of runtime divider input
//  INIT_CLKS  80   SCLK cycles of the power-up sequence (SPI_SD_INIT_EN only)
//  INIT_DIV   49   divider used for the power-up sequence (SPI_SD_INIT_EN only)
// PORTS
//  clk       in   1                    system clock (40 MHz in SoC)
//  rst_n     in   1                    asynchronous active-low reset
//  start     in   1                    transfer request, sampled when busy=0
//  tx_data   in   DATA_W               word to send
//  cs_sel    in   $clog2(NUM_CS)+1     target CS index; >= NUM_CS = no CS (dummy clocks)
//  cs_hold   in   1                    1: keep CS asserted after this transfer
//  cpol      in   1                    SCLK idle level
//  cpha      in   1                    0: sample leading edge, 1: sample trailing edge
//  div       in   DIV_W                SCLK half-period = div+1 clk cycles
//  busy      out  1                    transfer or init in progress
//  done      out  1                    one-cycle pulse, rx_data valid
//  rx_data   out  DATA_W               last received word
//  spi_clk   out  1                    SCLK
//  spi_cs_n  out  NUM_CS               chip selects, active low
//  spi_mosi  out  1                    serial out
//  spi_miso  in   1                    serial in
// BEHAVIOUR
//  Reset (async, immediate, also mid-transfer): spi_clk=0, spi_cs_n=all 1, spi_mosi=1, done=0,
//   rx_data=0, busy=0 (busy=1 with SPI_SD_INIT_EN); FSM -> IDLE (INIT with macro).
//  States: INIT -> IDLE -> SETUP -> XFER -> DONE -> IDLE.
//  IDLE: start=1 latches tx_data/cs_sel/cs_hold/cpol/cpha/div; busy=1 next cycle. start with busy=1 ignored.
//  SETUP: selected cs_n low, spi_clk=cpol, MSB on mosi if cpha=0; lasts div+1 cycles.
//   Skipped if previous transfer held CS and cs_sel unchanged. If held CS differs: old CS released on entry.
//  XFER: 2*DATA_W half-periods of div+1 cycles each; spi_clk toggles at each boundary.
//   cpha=0: sample miso on leading edge, shift mosi on trailing edge; cpha=1: shift leading, sample trailing.
//   spi_clk returns to cpol after last half-period.
//  DONE (1 cycle): rx_data updated, done=1, busy=0; cs_n released unless cs_hold=1; mosi=1.
//  Latency start-edge to done: 1+(div+1)*(2*DATA_W+1) cycles; with held CS 1+(div+1)*2*DATA_W.
//  div=0: SCLK=clk/2. cs_sel>=NUM_CS: full transfer, all cs_n stay high.
//  Input changes during busy have no effect (all latched at start).
// CONFIGURATION
//  SPI_SD_INIT_EN defined: after reset FSM in INIT; all cs_n=1, mosi=1, emits INIT_CLKS SCLK cycles
//   (CPOL=0) at half-period INIT_DIV+1; busy=1 throughout, start ignored; then IDLE, busy=0.
//  Not defined: reset goes directly to IDLE, busy=0; INIT_CLKS/INIT_DIV unused.
// STRUCTURE
//  spi_pkg: FSM state enum (INIT,IDLE,SETUP,XFER,DONE), mode constants MODE0..MODE3, CS-none constant.
//  Sub-module spi_clk_gen: half-period counter, emits edge tick and leading/trailing flag; reloaded on start.
//  Top holds FSM, shift registers, CS decode/hold register.
// TESTING
//  Mode0, DATA_W=8, div=1, tx=0xA5, slave returns 0x3C -> MOSI A5 on rising edges, rx_data=0x3C, done at cycle 35.
//  Loop all modes 0..3 with miso=mosi loopback, tx=0x81 -> rx_data=0x81, SCLK idle = cpol each mode.
//  Burst cs_hold=1,1,0 on cs_sel=1, 3 bytes -> spi_cs_n[1] low continuous, done spacing 33 cycles, high after 3rd.
//  cs_sel=NUM_CS, div=0, tx=0xFF -> 8 SCLK cycles at clk/2, spi_cs_n all 1, done at cycle 18.
//  rst_n low mid-XFER (bit 4) -> same cycle spi_cs_n all 1, spi_clk=0, busy=0; next start completes normally.
//  SPI_SD_INIT_EN: after reset 80 SCLK cycles, period 100 clk, cs_n high, mosi high, start ignored, then busy=0.

Source files
------------

// File: rtl/spi_master_mc_pkg.sv
// Shared types for the multi-chip-select SPI master: FSM state encoding,
// SPI mode constants ({cpol, cpha}) and the inactive chip-select level.
package spi_master_mc_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam logic CS_NONE = 1'b1;

    // An edge samples MISO when it is the leading edge in CPHA=0 or the trailing edge in CPHA=1.
    function automatic logic is_sample_edge(input logic lead, input logic cpha);
        return lead ^ cpha;
    endfunction

endpackage

// File: rtl/spi_master_mc_if.sv
// Request/response bus between the peripheral register block (master modport)
// and the SPI master core (slave modport).
interface spi_master_mc_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
);
    localparam int CS_W = $clog2(NUM_CS) + 1;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic              cs_hold;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  div;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, cs_sel, cs_hold, cpol, cpha, div,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, cs_sel, cs_hold, cpol, cpha, div,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_mc_clk_gen.sv
// SCLK half-period timer: down-counter reloaded with div, ticks at terminal count
// and reports whether the tick ends a leading (1) or trailing (0) half-period.
module spi_master_mc_clk_gen #(
    parameter int DIV_W   = 8,
    parameter int RST_CNT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             lead_q, lead_d;

    assign tick = en && (cnt_q == '0);
    assign lead = lead_q;

    always_comb begin
        cnt_d  = cnt_q;
        lead_d = lead_q;
        if (load) begin
            cnt_d  = div;
            lead_d = 1'b1;
        end else if (tick) begin
            cnt_d  = div;
            lead_d = ~lead_q;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= DIV_W'(RST_CNT);
            lead_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            lead_q <= lead_d;
        end
    end
endmodule

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master, all CPOL/CPHA modes, runtime divider, CS hold across bursts.
// Optional SD power-up clock sequence after reset when SPI_SD_INIT_EN is defined.
//
// state | meaning
// INIT  | SD power-up: INIT_CLKS SCLK cycles with CS released, MOSI high
// IDLE  | waiting for start, request fields latched on start
// SETUP | CS asserted, one half-period before the first SCLK edge
// XFER  | 2*DATA_W half-periods, SCLK toggles at each tick
// DONE  | publish rx_data, pulse done, release CS unless held
module spi_master_mc
    import spi_master_mc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CS    = 2,
    parameter int DIV_W     = 8,
    parameter int INIT_CLKS = 80,
    parameter int INIT_DIV  = 49
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_mc_if.slave    bus,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int CS_W   = $clog2(NUM_CS) + 1;
    localparam int EC_MAX = (INIT_CLKS > DATA_W) ? 2 * INIT_CLKS : 2 * DATA_W;
    localparam int EC_W   = $clog2(EC_MAX + 1);

`ifdef SPI_SD_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    localparam logic   RST_BUSY  = 1'b1;
    localparam int     RST_EDGES = 2 * INIT_CLKS;
    localparam int     RST_CNT   = INIT_DIV;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
    localparam int     RST_EDGES = 0;
    localparam int     RST_CNT   = 0;
`endif

    state_t            state_q, state_d;
    logic              spi_clk_q, spi_clk_d, spi_mosi_q, spi_mosi_d;
    logic [NUM_CS-1:0] spi_cs_n_q, spi_cs_n_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [EC_W-1:0]   edges_q, edges_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, cs_hold_q, cs_hold_d, held_q, held_d;
    logic [DIV_W-1:0]  div_q, div_d, gen_div;
    logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
    logic              gen_en, gen_load, tick, lead;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = {NUM_CS{CS_NONE}};
        for (int i = 0; i < NUM_CS; i++)
            if (sel == CS_W'(i)) v[i] = ~CS_NONE;
        return v;
    endfunction

    always_comb begin
        case (state_q)
            ST_IDLE: gen_div = bus.div;
            ST_INIT: gen_div = DIV_W'(INIT_DIV);
            default: gen_div = div_q;
        endcase
    end

    spi_master_mc_clk_gen #(.DIV_W(DIV_W), .RST_CNT(RST_CNT)) u_clk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (gen_en),
        .load (gen_load),
        .div  (gen_div),
        .tick (tick),
        .lead (lead)
    );

    always_comb begin
        state_d    = state_q;
        spi_clk_d  = spi_clk_q;
        spi_mosi_d = spi_mosi_q;
        spi_cs_n_d = spi_cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edges_d    = edges_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cs_hold_d  = cs_hold_q;
        held_d     = held_q;
        div_d      = div_q;
        cs_sel_d   = cs_sel_q;
        gen_en     = (state_q == ST_INIT) || (state_q == ST_SETUP) || (state_q == ST_XFER);
        gen_load   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (tick) begin
                    spi_clk_d = ~spi_clk_q;
                    edges_d   = edges_q - 1'b1;
                    if (edges_q == EC_W'(1)) begin
                        spi_clk_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    cpol_d     = bus.cpol;
                    cpha_d     = bus.cpha;
                    div_d      = bus.div;
                    cs_hold_d  = bus.cs_hold;
                    cs_sel_d   = bus.cs_sel;
                    busy_d     = 1'b1;
                    gen_load   = 1'b1;
                    edges_d    = EC_W'(2 * DATA_W);
                    spi_clk_d  = bus.cpol;
                    spi_cs_n_d = cs_decode(bus.cs_sel);
                    // CPHA=0 needs the MSB valid before the first (sampling) edge.
                    tx_sr_d    = bus.cpha ? bus.tx_data : (bus.tx_data << 1);
                    spi_mosi_d = bus.cpha ? 1'b1 : bus.tx_data[DATA_W-1];
                    if (held_q && (bus.cs_sel == cs_sel_q)) state_d = ST_XFER;
                    else                                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    gen_load = 1'b1;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    spi_clk_d = ~spi_clk_q;
                    edges_d   = edges_q - 1'b1;
                    if (is_sample_edge(lead, cpha_q)) begin
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], spi_miso};
                    end else begin
                        spi_mosi_d = tx_sr_q[DATA_W-1];
                        tx_sr_d    = tx_sr_q << 1;
                    end
                    if (edges_q == EC_W'(1)) begin
                        spi_clk_d  = cpol_q;
                        spi_mosi_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                rx_data_d  = rx_sr_q;
                spi_mosi_d = 1'b1;
                held_d     = cs_hold_q;
                if (!cs_hold_q) spi_cs_n_d = {NUM_CS{CS_NONE}};
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            spi_clk_q  <= 1'b0;
            spi_mosi_q <= 1'b1;
            spi_cs_n_q <= {NUM_CS{CS_NONE}};
            busy_q     <= RST_BUSY;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edges_q    <= EC_W'(RST_EDGES);
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_hold_q  <= 1'b0;
            held_q     <= 1'b0;
            div_q      <= '0;
            cs_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            spi_clk_q  <= spi_clk_d;
            spi_mosi_q <= spi_mosi_d;
            spi_cs_n_q <= spi_cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edges_q    <= edges_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cs_hold_q  <= cs_hold_d;
            held_q     <= held_d;
            div_q      <= div_d;
            cs_sel_q   <= cs_sel_d;
        end
    end

    assign spi_clk     = spi_clk_q;
    assign spi_mosi    = spi_mosi_q;
    assign spi_cs_n    = spi_cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule
